// File: rtl/mux4_rr_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// FSM encodings, requester count, default hold limit and a one-hot helper.
package mux4_rr_arb_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned MAX_HOLD_DEF = 16;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arb_rr_pick4.sv
// Combinational round-robin picker: first set bit of (req & ~excl)
// scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
  import mux4_rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [1:0]         win,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         idx;

  // Scanning from the farthest slot down leaves the nearest candidate in win.
  always_comb begin
    cand = req & ~excl;
    win  = 2'd0;
    any  = 1'b0;
    idx  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) begin
        win = idx;
        any = 1'b1;
      end else begin
        win = win;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter and registered 4:1 data mux for four requesters.
// Optional per-owner hold limit enabled by defining MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arb
  import mux4_rr_arb_pkg::*;
#(
  parameter int unsigned DW       = 2,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DW-1:0]      p0,
  input  logic [DW-1:0]      p1,
  input  logic [DW-1:0]      p2,
  input  logic [DW-1:0]      p3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic [DW-1:0]      sout,
  output logic               sout_vld
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be within 2..255");
  end

  logic [0:0]         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [DW-1:0]      sout_q, sout_d;
  logic               sout_vld_q, sout_vld_d;
  logic [NUM_REQ-1:0] excl;
  logic [1:0]         win;
  logic               any;
  logic               grant_new;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       hold_expired;
  assign hold_expired = (state_q == ARB_BUSY) && req[sel_q] && (hold_cnt_q == HOLD_LAST);
`endif

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .excl (excl),
    .win  (win),
    .any  (any)
  );

  // Grant FSM: hold, hand over without a bubble, or fall back to idle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    grant_new = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
    excl = hold_expired ? onehot4(sel_q) : 4'b0000;
`else
    excl = 4'b0000;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          grant_new = 1'b1;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      ARB_BUSY: begin
        if (req[sel_q]) begin
`ifdef MUX4_ARB_TIMEOUT_EN
          // At the limit, any here means a requester other than the owner.
          if (hold_expired && any) begin
            grant_new = 1'b1;
          end else begin
            grant_new = 1'b0;
          end
`else
          grant_new = 1'b0;
`endif
        end else if (any) begin
          grant_new = 1'b1;
        end else begin
          gnt_d   = 4'b0000;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = ARB_IDLE;
      end
    endcase
    if (grant_new) begin
      gnt_d   = onehot4(win);
      sel_d   = win;
      ptr_d   = win;
      state_d = ARB_BUSY;
    end else begin
      ptr_d = ptr_d;
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  // Hold counter: cleared on each new grant, saturates at the limit.
  always_comb begin
    if (grant_new || state_d != ARB_BUSY) begin
      hold_cnt_d = 8'd0;
    end else if (hold_cnt_q < HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  // Output data path samples the granted input one cycle after the grant.
  always_comb begin
    sout_vld_d = |gnt_q;
    if (|gnt_q) begin
      case (sel_q)
        2'd0:    sout_d = p0;
        2'd1:    sout_d = p1;
        2'd2:    sout_d = p2;
        2'd3:    sout_d = p3;
        default: sout_d = sout_q;
      endcase
    end else begin
      sout_d = sout_q;
    end
  end

  // ptr resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= 2'd3;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      sout_q     <= '0;
      sout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      sout_q     <= sout_d;
      sout_vld_q <= sout_vld_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign sout     = sout_q;
  assign sout_vld = sout_vld_q;

endmodule
